round_key_fetch: RTL
====================

ROUND_KEY_FETCH -- requirements
Module: round_key_fetch

Interface
REQ-001 SHALL have parameter KEY_BASE_ADDR, default 16'h0000, meaning the SRAM word address of the round-0 key.
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning the cycles sramRead is held before read data is sampled (legal range 1-7).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, the request; a rising edge starts a fetch.
REQ-006 SHALL have port roundNum, input, 4, the requested AES round (0-10).
REQ-007 SHALL have port decrypt, input, 1; when 1, the effective round is 10 - roundNum.
REQ-008 SHALL have port sramReadValue, input, 128, the SRAM read data.
REQ-009 SHALL have port sramRead, output, 1, the SRAM read strobe.
REQ-010 SHALL have port sramAddr, output, 16, the SRAM word address.
REQ-011 SHALL have port roundKey, output, 128, the fetched round key.
REQ-012 SHALL have port keyValid, output, 1; when 1, roundKey holds the key for the last completed request.
REQ-013 SHALL have port fetchDone, output, 1, a one-cycle completion pulse.
REQ-014 SHALL have port fetchError, output, 1, a one-cycle pulse for an illegal request.

Function
REQ-015 SHALL implement the states IDLE, READ, DONE and ERR.
REQ-016 SHALL, in IDLE, register enable and detect its rising edge (enable=1 and previous enable=0).
REQ-017 SHALL, on a rising edge with roundNum>10, go to ERR; ERR pulses fetchError for 1 cycle, makes no SRAM access, leaves keyValid and roundKey unchanged, then returns to IDLE.
REQ-018 SHALL, on a valid request, latch the effective round effRound.
REQ-019 SHALL treat a request as a cache hit when keyValid=1 and effRound equals the cached round; a hit goes directly to DONE with no SRAM access.
REQ-020 SHALL treat any other valid request as a miss and go to READ.
REQ-021 SHALL, in READ, drive sramRead=1 and sramAddr=KEY_BASE_ADDR+effRound (16-bit, wrap-around permitted), both held stable for exactly READ_LATENCY cycles.
REQ-022 SHALL count the READ cycles with a counter.
REQ-023 SHALL sample sramReadValue into roundKey on the clock edge ending the last READ cycle, and update the cached round at the same edge.
REQ-024 SHALL, in DONE, assert fetchDone=1 and keyValid=1 for exactly one cycle, then return to IDLE.
REQ-025 SHALL hold keyValid high after DONE until reset.
REQ-026 SHALL meet these latencies, with the rising edge sampled at edge N: miss gives fetchDone high in cycle N+READ_LATENCY+1; hit gives fetchDone high in cycle N+1.
REQ-027 SHALL let a fetch run to completion, with fetchDone still pulsing, if enable falls during READ.
REQ-028 SHALL ignore enable edges seen outside IDLE.
REQ-029 SHALL require a new 0->1 edge on enable to start another fetch; enable held high does not retrigger.
REQ-030 SHALL drive sramRead=0 and sramAddr=0 outside READ.
REQ-031 SHALL never assert any SRAM write.

Reset
REQ-032 SHALL, while n_rst=0, immediately force state=IDLE, sramRead=0, sramAddr=0, roundKey=0, keyValid=0, fetchDone=0, fetchError=0, cached round=0, counter=0 and the registered enable=0.
REQ-033 SHALL abort a READ in progress when reset asserts, with sramRead dropping without waiting for a clock.
REQ-034 SHALL emit no fetchDone for an aborted fetch.
REQ-035 SHALL, after reset, treat enable already high as not a rising edge.

Structure
REQ-036 SHALL take NUM_ROUNDS=10, KEY_WIDTH=128, SRAM_ADDR_WIDTH=16 and the state enum type from shared package aes_pkg.
REQ-037 SHALL implement the READ-cycle counter as one sub-module, flex_counter (3-bit, rollover value READ_LATENCY, clear on entering READ).
REQ-038 SHALL keep all other logic in round_key_fetch.

Verification
REQ-039 SHALL verify a miss: SRAM word 3 = 128'h0123...CDEF, enable edge with roundNum=3, decrypt=0, READ_LATENCY=1 -> sramRead=1 with sramAddr=3 for 1 cycle, fetchDone 2 cycles after the edge, roundKey=128'h0123...CDEF, keyValid=1.
REQ-040 SHALL verify a hit: repeat roundNum=3 -> no sramRead, fetchDone 1 cycle after the edge, roundKey unchanged.
REQ-041 SHALL verify decrypt mapping: decrypt=1, roundNum=2, KEY_BASE_ADDR=16'h0100 -> sramAddr=16'h0108, key of word 0x108 returned.
REQ-042 SHALL verify an illegal round: roundNum=12 -> fetchError pulses 1 cycle, sramRead stays 0, keyValid and roundKey unchanged.
REQ-043 SHALL verify reset mid-READ: READ_LATENCY=4, n_rst low in the 2nd READ cycle -> sramRead=0 immediately, keyValid=0, no fetchDone; enable held high after reset causes no fetch.
REQ-044 SHALL verify enable dropped mid-fetch: enable falls in the 1st READ cycle with READ_LATENCY=3 -> fetchDone still pulses 4 cycles after the edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
//   NUM_ROUNDS      - last legal AES round index
//   KEY_WIDTH       - round key width in bits
//   SRAM_ADDR_WIDTH - key SRAM word address width
//   fetch_state_e   - round_key_fetch controller states
package aes_pkg;
  localparam int NUM_ROUNDS      = 10;
  localparam int KEY_WIDTH       = 128;
  localparam int SRAM_ADDR_WIDTH = 16;
  localparam int ROUND_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/flex_counter.sv
// Cycle counter with synchronous clear and programmable rollover.
//   clk, n_rst    - clock, async active-low reset
//   clear         - synchronous clear to 0 (priority over count_enable)
//   count_enable  - advance the count by one
//   rollover_val  - number of counted cycles per period
//   rollover_flag - high while the current cycle is the last of the period
module flex_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);
  logic [WIDTH-1:0] count;

  // One bit wider so rollover_val at its max does not alias.
  assign rollover_flag = ({1'b0, count} + 1'b1) == {1'b0, rollover_val};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                      count <= '0;
    else if (clear)                  count <= '0;
    else if (count_enable) begin
      if (rollover_flag)             count <= '0;
      else                           count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/round_key_fetch.sv
// Fetches an AES round key from SRAM with a one-entry cache.
//   clk, n_rst        - clock, async active-low reset
//   enable            - request; a rising edge starts a fetch
//   roundNum, decrypt - requested round; decrypt maps it to 10 - roundNum
//   sramReadValue     - SRAM read data
//   sramRead/sramAddr - SRAM read strobe and word address (read only)
//   roundKey/keyValid - last fetched key and its validity
//   fetchDone         - one-cycle completion pulse
//   fetchError        - one-cycle pulse for roundNum > 10
module round_key_fetch
  import aes_pkg::*;
#(
  parameter logic [SRAM_ADDR_WIDTH-1:0] KEY_BASE_ADDR = 16'h0000,
  parameter int                         READ_LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       enable,
  input  logic [ROUND_W-1:0]         roundNum,
  input  logic                       decrypt,
  input  logic [KEY_WIDTH-1:0]       sramReadValue,
  output logic                       sramRead,
  output logic [SRAM_ADDR_WIDTH-1:0] sramAddr,
  output logic [KEY_WIDTH-1:0]       roundKey,
  output logic                       keyValid,
  output logic                       fetchDone,
  output logic                       fetchError
);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  fetch_state_e         state, next_state;
  logic                 enable_q;
  logic                 seen_low;   // enable observed low since reset
  logic [ROUND_W-1:0]   eff_round, cached_round, eff_next;
  logic [KEY_WIDTH-1:0] key_q;
  logic                 key_valid_q;
  logic                 rise, req_bad, hit, cnt_clear, last_read;

  // seen_low keeps an enable already high at reset release from counting as an edge.
  assign rise     = enable && !enable_q && seen_low;
  assign req_bad  = roundNum > LAST_ROUND;
  assign eff_next = decrypt ? (LAST_ROUND - roundNum) : roundNum;
  assign hit      = key_valid_q && (eff_next == cached_round);

  flex_counter #(.WIDTH(3)) u_read_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (state == READ),
    .rollover_val (3'(READ_LATENCY)),
    .rollover_flag(last_read)
  );

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    case (state)
      IDLE: if (rise) begin
        if (req_bad)  next_state = ERR;
        else if (hit) next_state = DONE;
        else begin
          next_state = READ;
          cnt_clear  = 1'b1;
        end
      end
      READ:    if (last_read) next_state = DONE;
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      enable_q     <= 1'b0;
      seen_low     <= 1'b0;
      eff_round    <= '0;
      cached_round <= '0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
    end else begin
      state    <= next_state;
      enable_q <= enable;
      if (!enable) seen_low <= 1'b1;
      if (state == IDLE && rise && !req_bad) eff_round <= eff_next;
      if (state == READ && last_read) begin
        key_q        <= sramReadValue;
        cached_round <= eff_round;
        key_valid_q  <= 1'b1;
      end
    end
  end

  // Decoded from state so an async reset drops the strobe immediately.
  assign sramRead   = (state == READ);
  assign sramAddr   = (state == READ) ? KEY_BASE_ADDR + {{(SRAM_ADDR_WIDTH-ROUND_W){1'b0}}, eff_round}
                                      : '0;
  assign roundKey   = key_q;
  assign keyValid   = key_valid_q;
  assign fetchDone  = (state == DONE);
  assign fetchError = (state == ERR);
endmodule
